// File: rtl/pixel_arbiter.sv
// Framebuffer port arbiter: display reads, a CPU pixel-write FIFO and an optional clear engine.
// Define PIXEL_ARB_CLEAR_EN to build the clear engine; without it clear_req is ignored.
module pixel_arbiter #(
  parameter int FB_AW      = 14,
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pixel_en,
  input  logic [31:0]      pixel_addr,
  input  logic             pixel_value,
  output logic             stall,
  output logic             drop_err,
  input  logic             disp_req,
  input  logic [FB_AW-1:0] disp_addr,
  output logic             disp_grant,
  output logic             disp_valid,
  output logic             disp_data,
  output logic [FB_AW-1:0] fb_addr,
  output logic             fb_we,
  output logic             fb_wdata,
  output logic             fb_re,
  input  logic             fb_rdata,
  input  logic             clear_req,
  output logic             clear_busy
);
  localparam int IW = $clog2(FIFO_DEPTH);
  localparam int PW = IW + 1;
  localparam int CW = $clog2(STARVE_MAX + 1);

  typedef struct packed {
    logic [FB_AW-1:0] addr;
    logic             val;
  } wr_t;

  wr_t             mem [FIFO_DEPTH];
  wr_t             head;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   starve_cnt;
  logic            full, empty, in_range, enq;
  logic            clearing, drain_ok, force_drain, fifo_we, clear_we;
  logic [FB_AW-1:0] clear_addr;

  assign full     = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign head     = mem[rd_ptr[IW-1:0]];
  assign in_range = ~|pixel_addr[31:FB_AW];
  assign enq      = pixel_en & in_range & ~full;

  // Out-of-range writes are dropped rather than stalled, even with a full FIFO.
  assign stall    = pixel_en & in_range & full;
  assign drop_err = ~rst & pixel_en & ~in_range;

  // The clear engine owns the FIFO's slot, so the FIFO neither drains nor starves while clearing.
  assign drain_ok    = ~empty & ~clearing;
  assign force_drain = drain_ok & (starve_cnt == CW'(STARVE_MAX));
  assign disp_grant  = ~rst & disp_req & ~force_drain;
  assign fifo_we     = drain_ok & ~disp_grant;

  assign fb_re    = disp_grant;
  assign fb_we    = fifo_we | clear_we;
  assign fb_wdata = fifo_we & head.val;
  assign disp_data = disp_valid & fb_rdata;

  always_comb begin
    fb_addr = '0;
    if (disp_grant)   fb_addr = disp_addr;
    else if (fifo_we) fb_addr = head.addr;
    else if (clear_we) fb_addr = clear_addr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      starve_cnt <= '0;
      disp_valid <= 1'b0;
    end else begin
      if (enq)     wr_ptr <= wr_ptr + 1'b1;
      if (fifo_we) rd_ptr <= rd_ptr + 1'b1;
      starve_cnt <= (disp_grant && drain_ok) ? starve_cnt + 1'b1 : '0;
      disp_valid <= disp_grant;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) mem[wr_ptr[IW-1:0]] <= '{addr: pixel_addr[FB_AW-1:0], val: pixel_value};
  end

`ifdef PIXEL_ARB_CLEAR_EN
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state, state_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      clear_addr <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && clear_req) clear_addr <= '0;
      else if (clear_we)              clear_addr <= clear_addr + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (clear_req) state_nxt = CLEAR;
      CLEAR: if (clear_we && clear_addr == '1) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    clearing   = (state == CLEAR);
    clear_busy = clearing;
    clear_we   = clearing & ~disp_grant;
  end
`else
  logic unused_clear;
  assign unused_clear = clear_req;
  assign clearing     = 1'b0;
  assign clear_we     = 1'b0;
  assign clear_busy   = 1'b0;
  assign clear_addr   = '0;
`endif
endmodule

// File: tb/tb_pixel_arbiter.sv
// Randomized scoreboard bench for pixel_arbiter with a queue-based reference model.
module tb_pixel_arbiter;
  localparam int FB_AW = 14, DEPTH = 4, SMAX = 8;
`ifdef PIXEL_ARB_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic clk, rst, pixel_en, pixel_value, stall, drop_err, disp_req, disp_grant, disp_valid, disp_data;
  logic [31:0] pixel_addr;
  logic [FB_AW-1:0] disp_addr, fb_addr;
  logic fb_we, fb_wdata, fb_re, fb_rdata, clear_req, clear_busy;

  pixel_arbiter #(.FB_AW(FB_AW), .FIFO_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst), .pixel_en(pixel_en), .pixel_addr(pixel_addr), .pixel_value(pixel_value),
    .stall(stall), .drop_err(drop_err), .disp_req(disp_req), .disp_addr(disp_addr),
    .disp_grant(disp_grant), .disp_valid(disp_valid), .disp_data(disp_data), .fb_addr(fb_addr),
    .fb_we(fb_we), .fb_wdata(fb_wdata), .fb_re(fb_re), .fb_rdata(fb_rdata),
    .clear_req(clear_req), .clear_busy(clear_busy));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: pending writes in order, grants since the FIFO last drained, clear progress.
  logic [FB_AW:0] wq[$];
  int  starve = 0;
  bit  clearing = 0;
  int  caddr = 0;
  bit  prev_grant = 0;

  always @(negedge clk) begin : monitor
    bit in_range, full, drainable, frc, e_grant, e_fifo_we, e_clr_we, accept;
    logic [FB_AW:0] w;
    if (rst) begin
      chk("rst_outs", 32'({stall, drop_err, disp_grant, disp_valid, disp_data, fb_we, fb_re, fb_wdata, clear_busy}), 32'd0);
      chk("rst_addr", 32'(fb_addr), 32'd0);
      wq.delete(); starve = 0; clearing = 0; caddr = 0; prev_grant = 0;
    end else begin
      in_range  = (pixel_addr >> FB_AW) == 0;
      full      = wq.size() == DEPTH;
      drainable = wq.size() > 0 && !clearing;
      frc       = drainable && starve == SMAX;
      e_grant   = disp_req && !frc;
      e_fifo_we = drainable && !e_grant;
      e_clr_we  = clearing && !e_grant;
      accept    = pixel_en && in_range && !full;

      chk("stall", 32'(stall), 32'(pixel_en && in_range && full));
      chk("drop_err", 32'(drop_err), 32'(pixel_en && !in_range));
      chk("disp_grant", 32'(disp_grant), 32'(e_grant));
      chk("fb_re", 32'(fb_re), 32'(e_grant));
      chk("fb_we", 32'(fb_we), 32'(e_fifo_we || e_clr_we));
      chk("disp_valid", 32'(disp_valid), 32'(prev_grant));
      chk("disp_data", 32'(disp_data), 32'(prev_grant && fb_rdata));
      chk("clear_busy", 32'(clear_busy), 32'(clearing));
      if (e_grant) chk("rd_addr", 32'(fb_addr), 32'(disp_addr));

      if (e_fifo_we) begin
        w = wq.pop_front();
        chk("wr_addr", 32'(fb_addr), 32'(w[FB_AW:1]));
        chk("wr_data", 32'(fb_wdata), 32'(w[0]));
      end else if (e_clr_we) begin
        chk("clr_addr", 32'(fb_addr), 32'(caddr));
        chk("clr_data", 32'(fb_wdata), 32'd0);
      end
      if (accept) wq.push_back({pixel_addr[FB_AW-1:0], pixel_value});

      starve = (e_grant && drainable) ? starve + 1 : 0;
      prev_grant = e_grant;
      if (clearing) begin
        if (e_clr_we) begin
          if (caddr == (1 << FB_AW) - 1) clearing = 0;
          else caddr++;
        end
      end else if (CLR && clear_req) begin
        clearing = 1; caddr = 0;
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic idle();
    pixel_en = 0; disp_req = 0; clear_req = 0; pixel_addr = '0; pixel_value = 0;
  endtask

  initial begin
    int n;
    rst = 1; fb_rdata = 0; disp_addr = '0; idle();
    cyc(2);
    rst = 0;
    cyc(2);

    // single write, no display traffic
    pixel_en = 1; pixel_addr = 32'h0000_0105; pixel_value = 1;
    cyc(); idle(); cyc(4);

    // five writes against continuous display reads, CPU holds on stall
    disp_req = 1; disp_addr = 14'h0033;
    for (int i = 0; i < 5; i++) begin
      pixel_en = 1; pixel_addr = 32'(i * 7 + 1); pixel_value = 1'(i);
      cyc();
      while (stall) cyc();
    end
    pixel_en = 0;
    cyc(40); idle(); cyc(4);

    // out-of-range write
    pixel_en = 1; pixel_addr = 32'h0000_4000; pixel_value = 1;
    cyc(); idle(); cyc(3);

    // display read returning 1
    disp_req = 1; disp_addr = 14'h0010; fb_rdata = 1;
    cyc(); disp_req = 0; cyc(2); fb_rdata = 0; cyc(2);

    // randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      pixel_en    = ($urandom_range(0, 1) == 1);
      pixel_addr  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, (1 << FB_AW) - 1));
      pixel_value = 1'($urandom_range(0, 1));
      disp_req    = ($urandom_range(0, 9) < 7);
      disp_addr   = 14'($urandom_range(0, (1 << FB_AW) - 1));
      fb_rdata    = 1'($urandom_range(0, 1));
      clear_req   = CLR ? 1'b0 : ($urandom_range(0, 49) == 0);
      rst         = ($urandom_range(0, 499) == 0);
      cyc();
    end
    rst = 0; idle(); cyc(10);

`ifdef PIXEL_ARB_CLEAR_EN
    // full clear with no other traffic
    clear_req = 1; cyc(); clear_req = 0;
    n = 0;
    while (n < 20000) begin
      @(negedge clk);
      if (!clear_busy) break;
      n++;
    end
    chk("clear_len", 32'(n), 32'd16384);
    cyc(5);

    // reset aborts a clear part way through
    clear_req = 1; cyc(); clear_req = 0;
    cyc(32'h200);
    rst = 1; cyc(); rst = 0;
    cyc(50);
    chk("clear_abort_busy", 32'(clear_busy), 32'd0);

    // clear under random traffic: FIFO must hold writes and stall when full
    clear_req = 1; cyc(); clear_req = 0;
    for (int i = 0; i < 500; i++) begin
      pixel_en    = ($urandom_range(0, 1) == 1);
      pixel_addr  = 32'($urandom_range(0, (1 << FB_AW) - 1));
      pixel_value = 1'($urandom_range(0, 1));
      disp_req    = ($urandom_range(0, 2) == 0);
      disp_addr   = 14'($urandom_range(0, (1 << FB_AW) - 1));
      fb_rdata    = 1'($urandom_range(0, 1));
      clear_req   = ($urandom_range(0, 49) == 0);
      cyc();
    end
    idle(); rst = 1; cyc(); rst = 0; cyc(5);
`else
    clear_req = 1; cyc(); clear_req = 0; cyc(3);
    chk("no_clear_busy", 32'(clear_busy), 32'd0);
`endif

    idle(); cyc(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
